axi_write_arbiter: RTL
======================

Name: axi_write_arbiter

Overview:
- Shares one AXI write slave (address/data/response channels) among NM write masters.
- Grants one master at a time, round-robin, and holds the grant for a complete transaction: AW handshake, all W beats, B handshake.
- Sits between the master-side interconnect and the write slave. Checks burst length against WLAST and flags mismatches.

Parameters:
- NM, 2, number of masters (2..8)
- buswidth, 32, W data width
- GW, 3, grant index width; must satisfy 2**GW >= NM

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous active-high reset
- M_AWID  in  4*NM  per-master AWID, packed (master i at [4i+3:4i])
- M_AWADDR  in  32*NM  per-master AWADDR
- M_AWLEN  in  4*NM  per-master AWLEN (beats-1)
- M_AWSIZE  in  3*NM  per-master AWSIZE
- M_AWBURST  in  2*NM  per-master AWBURST
- M_AWVALID  in  NM  per-master AWVALID
- M_AWREADY  out  NM  per-master AWREADY
- M_WDATA  in  buswidth*NM  per-master WDATA
- M_WSTRB  in  4*NM  per-master WSTRB
- M_WLAST  in  NM  per-master WLAST
- M_WVALID  in  NM  per-master WVALID
- M_WREADY  out  NM  per-master WREADY
- M_BID  out  4  broadcast BID
- M_BRESP  out  2  broadcast BRESP
- M_BVALID  out  NM  per-master BVALID
- M_BREADY  in  NM  per-master BREADY
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  4/32/4/3/2/1  slave AW channel
- AWREADY  in  1  slave AW ready
- WDATA/WSTRB/WLAST/WVALID  out  buswidth/4/1/1  slave W channel
- WREADY  in  1  slave W ready
- BID/BRESP/BVALID  in  4/2/1  slave B channel
- BREADY  out  1  slave B ready
- grant  out  GW  index of the current owner
- busy  out  1  high in ADDR/DATA/RESP
- len_err  out  1  one-cycle pulse on a burst length mismatch

Behaviour:
- State register, 4 states:
  - IDLE=0: no owner; all slave valids/readys and all M_*READY/M_BVALID are 0.
  - ADDR=1: AW path muxed from the granted master.
    - AWVALID = M_AWVALID[grant] and M_AWREADY[grant] = AWREADY.
    - All other AW fields come from grant.
    - On AWVALID&&AWREADY: latch AWLEN into len_q, clear beat_cnt, go to DATA.
  - DATA=2: W path muxed from the granted master.
    - WVALID/WDATA/WSTRB/WLAST come from grant; M_WREADY[grant] = WREADY.
    - Each WVALID&&WREADY increments beat_cnt (4-bit).
    - The beat closes the burst when WLAST=1 or beat_cnt==len_q; then go to RESP.
    - len_err pulses the next cycle if (WLAST && beat_cnt!=len_q) or (!WLAST && beat_cnt==len_q).
  - RESP=3: BREADY = M_BREADY[grant] and M_BVALID[grant] = BVALID.
    - M_BID/M_BRESP = BID/BRESP at all times.
    - On BVALID&&BREADY: last_q <= grant, go to IDLE.
- Arbitration:
  - In IDLE with any M_AWVALID set: pick the first requester scanning last_q+1, last_q+2, ... modulo NM. Register it into grant and go to ADDR.
  - One-cycle arbitration latency: the request is seen in cycle N, AWVALID is driven in cycle N+1.
  - No re-arbitration until the owner's B handshake completes, so only one transaction is outstanding.
- Non-granted masters always see M_AWREADY=M_WREADY=M_BVALID=0.
- A granted master that deasserts AWVALID in ADDR keeps the grant; the block waits, with no timeout.
- busy = (state != IDLE). grant holds its value in IDLE.
- Reset (ARESET=1 at a clock edge):
  - state=IDLE, grant=0, last_q=NM-1 (master 0 wins first), beat_cnt=0, len_q=0, len_err=0.
  - All handshake outputs are 0 from the following cycle.
- Reset mid-transaction abandons the transaction; no B is forwarded.
- Simultaneous requests resolve by round-robin order only; there is no fixed priority.
- Master index i in packed vectors always maps to bit slice i.

Test Plan:
- Reset, then M_AWVALID=2'b11 together -> master 0 granted (grant=0); after its B handshake, master 1 is granted next with no idle gap beyond 1 arbitration cycle.
- Master 1 issues AWLEN=3, AWBURST=01, 4 beats with WLAST on beat 4, slave WREADY toggling 1,0,1,0 -> exactly 4 W handshakes reach the slave, M_WREADY[0] stays 0, len_err stays 0, then BVALID routes only to M_BVALID[1].
- AWLEN=3 with WLAST asserted on beat 2 -> burst closes after 2 beats, len_err pulses once, state goes to RESP.
- Slave holds BVALID=1 while M_BREADY[grant]=0 for 5 cycles -> BREADY=0, state stays RESP, no new grant even with the other master requesting.
- ARESET asserted during DATA beat 2 -> next cycle busy=0, all M_*READY=0, WVALID=0; after release master 0 wins first.

Source files
------------

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI write slave among NM masters.
// One transaction (AW, W burst, B) is owned end to end by the granted master.
module axi_write_arbiter #(
    parameter int NM       = 2,
    parameter int buswidth = 32,
    parameter int GW       = 3
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [4*NM-1:0]        M_AWID,
    input  logic [32*NM-1:0]       M_AWADDR,
    input  logic [4*NM-1:0]        M_AWLEN,
    input  logic [3*NM-1:0]        M_AWSIZE,
    input  logic [2*NM-1:0]        M_AWBURST,
    input  logic [NM-1:0]          M_AWVALID,
    output logic [NM-1:0]          M_AWREADY,
    input  logic [buswidth*NM-1:0] M_WDATA,
    input  logic [4*NM-1:0]        M_WSTRB,
    input  logic [NM-1:0]          M_WLAST,
    input  logic [NM-1:0]          M_WVALID,
    output logic [NM-1:0]          M_WREADY,
    output logic [3:0]             M_BID,
    output logic [1:0]             M_BRESP,
    output logic [NM-1:0]          M_BVALID,
    input  logic [NM-1:0]          M_BREADY,
    output logic [3:0]             AWID,
    output logic [31:0]            AWADDR,
    output logic [3:0]             AWLEN,
    output logic [2:0]             AWSIZE,
    output logic [1:0]             AWBURST,
    output logic                   AWVALID,
    input  logic                   AWREADY,
    output logic [buswidth-1:0]    WDATA,
    output logic [3:0]             WSTRB,
    output logic                   WLAST,
    output logic                   WVALID,
    input  logic                   WREADY,
    input  logic [3:0]             BID,
    input  logic [1:0]             BRESP,
    input  logic                   BVALID,
    output logic                   BREADY,
    output logic [GW-1:0]          grant,
    output logic                   busy,
    output logic                   len_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    beat_cnt_q, beat_cnt_d;
    logic          len_err_q, len_err_d;
    logic [GW-1:0] pick;
    logic          any_req;

    // Round-robin pick: requester with the smallest distance after last_q.
    always_comb begin
        int best;
        best = NM;
        pick = '0;
        for (int i = 0; i < NM; i++) begin
            if (M_AWVALID[i] &&
                ((i + 2 * NM - int'(last_q) - 1) % NM) < best) begin
                best = (i + 2 * NM - int'(last_q) - 1) % NM;
                pick = GW'(i);
            end
        end
    end

    assign any_req = |M_AWVALID;

    // Route the granted master's channels to the slave, gated by phase.
    always_comb begin
        AWID      = '0;
        AWADDR    = '0;
        AWLEN     = '0;
        AWSIZE    = '0;
        AWBURST   = '0;
        AWVALID   = 1'b0;
        WDATA     = '0;
        WSTRB     = '0;
        WLAST     = 1'b0;
        WVALID    = 1'b0;
        BREADY    = 1'b0;
        M_AWREADY = '0;
        M_WREADY  = '0;
        M_BVALID  = '0;
        for (int i = 0; i < NM; i++) begin
            if (grant_q == GW'(i)) begin
                AWID         = M_AWID[4*i +: 4];
                AWADDR       = M_AWADDR[32*i +: 32];
                AWLEN        = M_AWLEN[4*i +: 4];
                AWSIZE       = M_AWSIZE[3*i +: 3];
                AWBURST      = M_AWBURST[2*i +: 2];
                WDATA        = M_WDATA[buswidth*i +: buswidth];
                WSTRB        = M_WSTRB[4*i +: 4];
                WLAST        = M_WLAST[i];
                AWVALID      = (state_q == ADDR) && M_AWVALID[i];
                M_AWREADY[i] = (state_q == ADDR) && AWREADY;
                WVALID       = (state_q == DATA) && M_WVALID[i];
                M_WREADY[i]  = (state_q == DATA) && WREADY;
                BREADY       = (state_q == RESP) && M_BREADY[i];
                M_BVALID[i]  = (state_q == RESP) && BVALID;
            end
        end
    end

    assign M_BID   = BID;
    assign M_BRESP = BRESP;
    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);
    assign len_err = len_err_q;

    // Transaction sequencing, burst beat tracking and length check.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (AWVALID && AWREADY) begin
                    len_d      = AWLEN;
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (WVALID && WREADY) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    len_err_d  = WLAST ^ (beat_cnt_q == len_q);
                    if (WLAST || beat_cnt_q == len_q) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (BVALID && BREADY) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= GW'(NM - 1);
            len_q      <= '0;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

endmodule
